// File: rtl/sdram_arbiter_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
// Widths match the SDRAM controller mode register and datapath.
package sdram_arbiter_pkg;

  localparam int unsigned WORD_LENGTH    = 16;
  localparam int unsigned ADDRESS_WIDTH  = 24;
  localparam int unsigned BURST_LENGTH   = 8;
  localparam int unsigned TIMEOUT_CYCLES = 4096;

  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned PORT_VGA  = 0;
  localparam int unsigned PORT_UART = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_BURST     = 3'd3,
    ST_FINISH    = 3'd4
  } arb_state_e;

  // One-hot grant vector for the selected port.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic sel_uart);
    return sel_uart ? NUM_PORTS'(2'b10) : NUM_PORTS'(2'b01);
  endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Two-way round-robin picker: a contested request goes to the port
// that did not own the previous grant.
module sdram_rr_pick
  import sdram_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last_uart,
  output logic [NUM_PORTS-1:0] grant_c
);

  always_comb begin
    grant_c = '0;
    if (req[PORT_VGA] && req[PORT_UART]) begin
      grant_c = port_onehot(!last_uart);
    end else if (req[PORT_VGA]) begin
      grant_c = port_onehot(1'b0);
    end else if (req[PORT_UART]) begin
      grant_c = port_onehot(1'b1);
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM controller between the VGA fetch and UART loader ports,
// sequencing one burst per grant and forwarding strobes to the owner only.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned WordLength    = WORD_LENGTH,
  parameter int unsigned AddressWidth  = ADDRESS_WIDTH,
  parameter int unsigned BurstLength   = BURST_LENGTH,
  parameter int unsigned TimeoutCycles = TIMEOUT_CYCLES
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_PORTS-1:0]    i_req,
  input  logic [NUM_PORTS-1:0]    i_rw,
  input  logic [AddressWidth-1:0] i_addr0,
  input  logic [AddressWidth-1:0] i_addr1,
  input  logic [WordLength-1:0]   i_wdata0,
  input  logic [WordLength-1:0]   i_wdata1,
  output logic [WordLength-1:0]   o_rdata,
  output logic [NUM_PORTS-1:0]    o_valid_wr,
  output logic [NUM_PORTS-1:0]    o_valid_rd,
  output logic [NUM_PORTS-1:0]    o_grant,
  output logic [NUM_PORTS-1:0]    o_done,
  output logic                    o_err,
  output logic                    o_sd_enable,
  output logic                    o_sd_rw,
  output logic [AddressWidth-1:0] o_sd_addr,
  output logic [WordLength-1:0]   o_sd_wdata,
  input  logic [WordLength-1:0]   i_sd_rdata,
  input  logic                    i_sd_valid_wr,
  input  logic                    i_sd_valid_rd,
  input  logic                    i_sd_busy
);

  localparam int unsigned TMO_W = $clog2(TimeoutCycles) + 1;
  localparam int unsigned CNT_W = 4;

  arb_state_e state_q, state_d;

  logic [NUM_PORTS-1:0]    grant_q, grant_d;
  logic                    last_uart_q, last_uart_d;
  logic                    rw_q, rw_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [NUM_PORTS-1:0]    done_q, done_d;
  logic                    err_q, err_d;

  logic [NUM_PORTS-1:0]    pick_c;
  logic                    timeout_c;

  sdram_rr_pick u_pick (
    .req       (i_req),
    .last_uart (last_uart_q),
    .grant_c   (pick_c)
  );

  assign timeout_c = (state_q != ST_IDLE) && (tmo_q == TMO_W'(TimeoutCycles));

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a timeout aborts from any active state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (|i_req)      state_d = ST_ISSUE;
      ST_ISSUE:     if (!i_sd_busy)  state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (i_sd_busy)   state_d = ST_BURST;
      ST_BURST:     if (!i_sd_busy)  state_d = ST_FINISH;
      ST_FINISH:                     state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
    if (timeout_c) begin
      state_d = ST_IDLE;
    end
  end

  // Combinational outputs: command strobe and zero-latency strobe forwarding
  always_comb begin
    o_sd_enable = 1'b0;
    o_valid_wr  = '0;
    o_valid_rd  = '0;
    o_rdata     = '0;
    o_sd_wdata  = '0;
    if (state_q == ST_ISSUE && !i_sd_busy) begin
      o_sd_enable = 1'b1;
    end
    if (state_q == ST_BURST) begin
      o_valid_wr = grant_q & {NUM_PORTS{i_sd_valid_wr}};
      o_valid_rd = grant_q & {NUM_PORTS{i_sd_valid_rd}};
      o_rdata    = i_sd_rdata;
    end
    if (grant_q[PORT_UART]) begin
      o_sd_wdata = i_wdata1;
    end else if (grant_q[PORT_VGA]) begin
      o_sd_wdata = i_wdata0;
    end
  end

  // Grant/command latch, read counter, timeout counter, completion pulses
  always_comb begin
    grant_d     = grant_q;
    last_uart_d = last_uart_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    rd_cnt_d    = rd_cnt_q;
    tmo_d       = tmo_q;
    done_d      = '0;
    err_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|i_req) begin
          grant_d  = pick_c;
          rw_d     = pick_c[PORT_UART] ? i_rw[PORT_UART] : i_rw[PORT_VGA];
          addr_d   = pick_c[PORT_UART] ? i_addr1 : i_addr0;
          rd_cnt_d = '0;
          tmo_d    = '0;
        end
      end
      ST_BURST: begin
        rd_cnt_d = rd_cnt_q + CNT_W'(i_sd_valid_rd);
        if (!i_sd_busy) begin
          done_d = grant_q;
          err_d  = rw_q && (rd_cnt_d != CNT_W'(BurstLength));
        end
      end
      ST_FINISH: begin
        grant_d     = '0;
        last_uart_d = grant_q[PORT_UART];
      end
      default: ;
    endcase
    if (state_q != ST_IDLE) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
    if (timeout_c) begin
      grant_d = '0;
      done_d  = '0;
      err_d   = 1'b1;
    end
  end

  // Datapath registers; last-grant resets to UART so VGA wins first
  always_ff @(posedge CLK) begin
    if (!RST) begin
      grant_q     <= '0;
      last_uart_q <= 1'b1;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      rd_cnt_q    <= '0;
      tmo_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      last_uart_q <= last_uart_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      rd_cnt_q    <= rd_cnt_d;
      tmo_q       <= tmo_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign o_grant   = grant_q;
  assign o_done    = done_q;
  assign o_err     = err_q;
  assign o_sd_rw   = rw_q;
  assign o_sd_addr = addr_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter with a behavioural SDRAM controller
// stub and a write client that advances its word after each write strobe.
module tb_sdram_arbiter;

  logic        CLK;
  logic        RST;
  logic [1:0]  i_req;
  logic [1:0]  i_rw;
  logic [23:0] i_addr0, i_addr1;
  logic [15:0] i_wdata0, i_wdata1;
  logic [15:0] o_rdata;
  logic [1:0]  o_valid_wr, o_valid_rd, o_grant, o_done;
  logic        o_err, o_sd_enable, o_sd_rw;
  logic [23:0] o_sd_addr;
  logic [15:0] o_sd_wdata;
  logic [15:0] i_sd_rdata;
  logic        i_sd_valid_wr, i_sd_valid_rd, i_sd_busy;

  sdram_arbiter dut (
    .CLK(CLK), .RST(RST),
    .i_req(i_req), .i_rw(i_rw),
    .i_addr0(i_addr0), .i_addr1(i_addr1),
    .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
    .o_rdata(o_rdata), .o_valid_wr(o_valid_wr), .o_valid_rd(o_valid_rd),
    .o_grant(o_grant), .o_done(o_done), .o_err(o_err),
    .o_sd_enable(o_sd_enable), .o_sd_rw(o_sd_rw), .o_sd_addr(o_sd_addr),
    .o_sd_wdata(o_sd_wdata), .i_sd_rdata(i_sd_rdata),
    .i_sd_valid_wr(i_sd_valid_wr), .i_sd_valid_rd(i_sd_valid_rd),
    .i_sd_busy(i_sd_busy)
  );

  typedef struct packed {
    logic [1:0]  port_oh;
    logic        rw;
    logic [23:0] addr;
  } cmd_t;

  cmd_t        cmd_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] wr_q[$];
  logic [1:0]  done_q[$];

  int checks = 0;
  int errors = 0;
  int en_count = 0;
  int refresh_req = 0;
  bit no_busy = 1'b0;
  logic [15:0] wexp0 = 16'h2000;
  logic [15:0] wexp1 = 16'h1000;
  logic [15:0] wr_cnt0, wr_cnt1;

  assign i_wdata0 = 16'h2000 + wr_cnt0;
  assign i_wdata1 = 16'h1000 + wr_cnt1;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Controller stub read data: address 0x012340 yields 0xA0, 0xA1, ...
  function automatic logic [15:0] rd_word(input logic [23:0] a, input int i);
    return (a[15:0] ^ 16'h23E0) + 16'(i);
  endfunction

  // Controller stub: refresh episodes, or an 8-word burst per accepted command
  initial begin : ctrl_model
    int served;
    logic m_rw;
    logic [23:0] m_addr;
    served = 0;
    i_sd_busy = 1'b0; i_sd_valid_rd = 1'b0; i_sd_valid_wr = 1'b0; i_sd_rdata = '0;
    forever begin
      @(negedge CLK);
      if (refresh_req != served) begin
        served++;
        @(posedge CLK); #1 i_sd_busy = 1'b1;
        repeat (200) begin @(posedge CLK); #1; end
        i_sd_busy = 1'b0;
      end else if (o_sd_enable && !no_busy && RST) begin
        m_rw = o_sd_rw;
        m_addr = o_sd_addr;
        @(posedge CLK); #1 i_sd_busy = 1'b1;
        @(posedge CLK); #1;
        for (int i = 0; i < 8 && RST; i++) begin
          if (m_rw) begin
            i_sd_valid_rd = 1'b1;
            i_sd_rdata = rd_word(m_addr, i);
          end else begin
            i_sd_valid_wr = 1'b1;
          end
          @(posedge CLK); #1;
        end
        i_sd_valid_rd = 1'b0; i_sd_valid_wr = 1'b0; i_sd_busy = 1'b0;
      end
    end
  end

  // Write clients advance their word the cycle after each write strobe
  initial begin : client
    logic w0, w1;
    wr_cnt0 = '0; wr_cnt1 = '0;
    forever begin
      @(negedge CLK);
      w0 = o_valid_wr[0];
      w1 = o_valid_wr[1];
      @(posedge CLK); #1;
      if (w0) wr_cnt0 = wr_cnt0 + 16'd1;
      if (w1) wr_cnt1 = wr_cnt1 + 16'd1;
    end
  end

  // Monitor: pops expectations as the DUT produces commands, data and completions
  initial begin : monitor
    logic prev_en;
    logic [1:0] exp_oh;
    cmd_t c;
    prev_en = 1'b0;
    exp_oh = 2'b00;
    forever begin
      @(negedge CLK);
      check("grant_onehot0", 32'($onehot0(o_grant)), 32'd1);
      if (o_sd_enable) begin
        en_count++;
        check("en_single_cycle", 32'(prev_en), 32'd0);
        check("en_while_idle", 32'(i_sd_busy), 32'd0);
        if (cmd_q.size() == 0) begin
          check("cmd_unexpected", 32'(cmd_q.size()), 32'd1);
        end else begin
          c = cmd_q.pop_front();
          exp_oh = c.port_oh;
          check("cmd_grant", 32'(o_grant), 32'(c.port_oh));
          check("cmd_rw", 32'(o_sd_rw), 32'(c.rw));
          check("cmd_addr", 32'(o_sd_addr), 32'(c.addr));
        end
      end
      prev_en = o_sd_enable;
      if (o_valid_rd != 2'b00) begin
        check("valid_rd_port", 32'(o_valid_rd), 32'(exp_oh));
        if (rd_q.size() == 0) check("rd_unexpected", 32'(rd_q.size()), 32'd1);
        else check("rdata", 32'(o_rdata), 32'(rd_q.pop_front()));
      end
      if (o_valid_wr != 2'b00) begin
        check("valid_wr_port", 32'(o_valid_wr), 32'(exp_oh));
        if (wr_q.size() == 0) check("wr_unexpected", 32'(wr_q.size()), 32'd1);
        else check("sd_wdata", 32'(o_sd_wdata), 32'(wr_q.pop_front()));
      end
      if (o_done != 2'b00) begin
        if (done_q.size() == 0) check("done_unexpected", 32'(done_q.size()), 32'd1);
        else check("done_port", 32'(o_done), 32'(done_q.pop_front()));
        check("done_no_err", 32'(o_err), 32'd0);
      end
    end
  end

  task automatic push_burst(input int port, input logic rw, input logic [23:0] addr,
                            input bit with_data, input bit with_done);
    cmd_t c;
    c.port_oh = (port == 1) ? 2'b10 : 2'b01;
    c.rw = rw;
    c.addr = addr;
    cmd_q.push_back(c);
    if (with_data) begin
      for (int i = 0; i < 8; i++) begin
        if (rw) begin
          rd_q.push_back(rd_word(addr, i));
        end else if (port == 1) begin
          wr_q.push_back(wexp1); wexp1 = wexp1 + 16'd1;
        end else begin
          wr_q.push_back(wexp0); wexp0 = wexp0 + 16'd1;
        end
      end
    end
    if (with_done) done_q.push_back(c.port_oh);
  endtask

  task automatic set_port(input int port, input logic rw, input logic [23:0] addr);
    if (port == 1) begin i_rw[1] = rw; i_addr1 = addr; end
    else begin i_rw[0] = rw; i_addr0 = addr; end
  endtask

  // One request held until its done; optionally checks request-to-enable latency
  task automatic run_burst(input int port, input logic rw, input logic [23:0] addr,
                           input int lat_exp, input int budget, output int en_at);
    int n;
    bit got;
    push_burst(port, rw, addr, 1'b1, 1'b1);
    @(posedge CLK); #1;
    set_port(port, rw, addr);
    i_req[port] = 1'b1;
    n = 0; got = 1'b0; en_at = 0;
    while (!got && n < budget) begin
      @(negedge CLK);
      n++;
      if (o_sd_enable && en_at == 0) en_at = n;
      if (o_done[port]) got = 1'b1;
    end
    check("burst_done_seen", 32'(got), 32'd1);
    if (lat_exp >= 0) check("req_to_enable", 32'(en_at), 32'(lat_exp));
    @(posedge CLK); #1;
    i_req[port] = 1'b0;
  endtask

  initial begin : main
    int n, en_at, err_at, seen, e0;
    bit got;
    RST = 1'b0; i_req = 2'b00; i_rw = 2'b00; i_addr0 = '0; i_addr1 = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_enable", 32'(o_sd_enable), 32'd0);
    check("rst_sd_addr", 32'(o_sd_addr), 32'd0);
    check("rst_sd_wdata", 32'(o_sd_wdata), 32'd0);
    @(posedge CLK); #1 RST = 1'b1;

    // Single read on VGA port, single write on UART port
    run_burst(0, 1'b1, 24'h012340, 2, 100, en_at);
    run_burst(1, 1'b0, 24'h000008, 2, 100, en_at);

    // Both ports request continuously: grants alternate 0,1,0,1
    push_burst(0, 1'b1, 24'h000100, 1'b1, 1'b1);
    push_burst(1, 1'b0, 24'h000200, 1'b1, 1'b1);
    push_burst(0, 1'b1, 24'h000100, 1'b1, 1'b1);
    push_burst(1, 1'b0, 24'h000200, 1'b1, 1'b1);
    @(posedge CLK); #1;
    set_port(0, 1'b1, 24'h000100);
    set_port(1, 1'b0, 24'h000200);
    i_req = 2'b11;
    n = 0; seen = 0;
    while (seen < 4 && n < 300) begin
      @(negedge CLK);
      n++;
      if (o_done != 2'b00) seen++;
    end
    check("arb_bursts", 32'(seen), 32'd4);
    @(posedge CLK); #1 i_req = 2'b00;

    // Request during a 200-cycle refresh: command withheld, then issued once
    refresh_req++;
    repeat (3) @(posedge CLK);
    e0 = en_count;
    run_burst(0, 1'b1, 24'h000300, -1, 400, en_at);
    check("refresh_withheld", 32'(en_at >= 150), 32'd1);
    check("refresh_issued_once", 32'(en_count), 32'(e0 + 1));

    // Controller never goes busy: abort at the timeout, then the held request is re-served
    no_busy = 1'b1;
    push_burst(0, 1'b1, 24'h000700, 1'b0, 1'b0);
    @(posedge CLK); #1;
    set_port(0, 1'b1, 24'h000700);
    i_req[0] = 1'b1;
    n = 0; en_at = 0; err_at = 0;
    while (err_at == 0 && n < 5000) begin
      @(negedge CLK);
      n++;
      if (o_sd_enable && en_at == 0) en_at = n;
      if (o_err) err_at = n;
    end
    check("tmo_err_seen", 32'(err_at != 0), 32'd1);
    check("tmo_latency", 32'((err_at - en_at) >= 4096 && (err_at - en_at) <= 4098), 32'd1);
    check("tmo_grant_clear", 32'(o_grant), 32'd0);
    check("tmo_no_done", 32'(o_done), 32'd0);
    no_busy = 1'b0;
    push_burst(0, 1'b1, 24'h000700, 1'b1, 1'b1);
    @(negedge CLK);
    check("tmo_err_one_cycle", 32'(o_err), 32'd0);
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(negedge CLK);
      n++;
      if (o_done[0]) got = 1'b1;
    end
    check("tmo_retry_done", 32'(got), 32'd1);
    @(posedge CLK); #1 i_req[0] = 1'b0;

    // Reset asserted in the middle of a read burst
    push_burst(0, 1'b1, 24'h000500, 1'b1, 1'b0);
    @(posedge CLK); #1;
    set_port(0, 1'b1, 24'h000500);
    i_req[0] = 1'b1;
    n = 0; seen = 0;
    while (seen < 3 && n < 60) begin
      @(negedge CLK);
      n++;
      if (o_valid_rd[0]) seen++;
    end
    check("mid_burst_reached", 32'(seen), 32'd3);
    RST = 1'b0;
    i_req = 2'b00;
    @(negedge CLK);
    check("mrst_grant", 32'(o_grant), 32'd0);
    check("mrst_done", 32'(o_done), 32'd0);
    check("mrst_err", 32'(o_err), 32'd0);
    check("mrst_enable", 32'(o_sd_enable), 32'd0);
    check("mrst_valid_rd", 32'(o_valid_rd), 32'd0);
    check("mrst_valid_wr", 32'(o_valid_wr), 32'd0);
    check("mrst_rdata", 32'(o_rdata), 32'd0);
    check("mrst_sd_addr", 32'(o_sd_addr), 32'd0);
    check("mrst_sd_rw", 32'(o_sd_rw), 32'd0);
    rd_q.delete();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    run_burst(0, 1'b1, 24'h000600, 2, 100, en_at);

    repeat (5) @(negedge CLK);
    check("queues_drained", 32'(cmd_q.size() + rd_q.size() + wr_q.size() + done_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
